cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
- Multicycle control FSM that drives the 16x16 register file, data memory and ALU of the 16-bit CPU.
- Owns the program counter (PC) and instruction register (IR), and sequences fetch, decode and execute.
- Issues the register file's write strobe, write address and both read addresses.
- Sits between the instruction ROM and the datapath.

Parameters:
PC_WIDTH, 7, instruction-memory address width; PC wraps modulo 2^PC_WIDTH
DADDR_WIDTH, 8, data-memory address width; equals IR[11:4] field width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears PC, IR, FSM
instr  in  16  instruction-ROM read data for pc_addr (combinational ROM)
pc_addr  out  PC_WIDTH  current PC to instruction ROM
d_addr  out  DADDR_WIDTH  data-memory address
d_wr  out  1  data-memory write strobe
rf_sel  out  1  register-file write mux: 0 = ALU result, 1 = data-memory read data
rf_w_addr  out  4  register-file write address
rf_w_en  out  1  register-file write strobe
rf_ra_addr  out  4  register-file A-side read address
rf_rb_addr  out  4  register-file B-side read address
alu_op  out  3  ALU function: 0 pass A, 1 A+B, 2 A-B
halted  out  1  high while in HALT
state_o  out  4  current FSM state encoding, for verification

Behaviour:
- Clock is clk. Reset is asynchronous and active-high on the port named reset.
- Instruction format: opcode IR[15:12].
  - NOOP 0x0.
  - STORE 0x1: mem[IR[11:4]] <= R[IR[3:0]].
  - LOAD 0x2: R[IR[3:0]] <= mem[IR[11:4]].
  - ADD 0x3: R[IR[3:0]] <= R[IR[11:8]] + R[IR[7:4]].
  - SUB 0x4: same fields as ADD, A minus B.
  - HALT 0x5.
  - Opcodes 0x6-0xF execute as NOOP.
- States: INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT.
- Outputs decode from state and IR only; no combinational path from instr to any output except via IR.
- Reset, asserted at any time including mid-instruction:
  - State goes to INIT, PC = 0, IR = 0.
  - All strobes (d_wr, rf_w_en) drop to 0 immediately, without waiting for an edge.
  - All address outputs = 0, alu_op = 0, rf_sel = 0, halted = 0.
- INIT: one cycle, PC held at 0, then FETCH.
- FETCH: at the next edge IR <= instr, PC <= PC+1 modulo 2^PC_WIDTH (2^PC_WIDTH-1 wraps to 0), then DECODE.
- DECODE: one cycle, no strobes. Branches on IR[15:12] to NOOP, LOAD_A, STORE, ADD, SUB or HALT.
- NOOP: one cycle, then FETCH.
- STORE:
  - d_addr = IR[11:4], rf_ra_addr = IR[3:0], d_wr = 1 for exactly one cycle.
  - Then FETCH.
- LOAD_A: d_addr = IR[11:4], rf_sel = 1, no strobes (synchronous memory read latency). Then LOAD_B.
- LOAD_B:
  - d_addr and rf_sel held; rf_w_addr = IR[3:0], rf_w_en = 1 for one cycle.
  - Then FETCH.
- ADD/SUB:
  - rf_ra_addr = IR[11:8], rf_rb_addr = IR[7:4], rf_w_addr = IR[3:0], rf_sel = 0.
  - alu_op = 1 or 2; rf_w_en = 1 for one cycle.
  - Then FETCH.
  - Same source and destination register is legal: the old value is read and the new value is written at the edge.
- HALT: halted = 1, all strobes 0, PC frozen. Remains until reset.
- Cycle counts per instruction, including FETCH and DECODE: NOOP/STORE/ADD/SUB 3 cycles, LOAD 4 cycles, HALT terminal.
- Outside the states listed above, d_wr, rf_w_en and rf_sel = 0. Address outputs hold IR-derived values or 0.
- At most one of d_wr and rf_w_en is high in any cycle.
- Unreachable state encodings go to INIT on the next edge.

Decomposition:
- Package cpu_pkg:
  - opcode_t enum (NOOP..HALT).
  - state_t enum.
  - ALU_PASS/ALU_ADD/ALU_SUB constants.
  - Field-position localparams for IR slices.
- One sub-module, cpu_pc: PC_WIDTH-bit counter with async reset, clear and increment inputs, plus wrap.
- FSM and IR live in cpu_control_unit.

Test Plan:
- Reset and first cycles: reset high 2 cycles, then released with instr=16'h3125 -> INIT 1 cycle, FETCH, DECODE, ADD:
  - In ADD: rf_ra_addr=1, rf_rb_addr=2, rf_w_addr=5, alu_op=1, rf_w_en=1 for exactly 1 cycle.
  - pc_addr=1 after FETCH.
- LOAD then STORE: program 16'h2A37, 16'h1A37.
  - LOAD_B: d_addr=0xA3, rf_sel=1, rf_w_addr=7, rf_w_en=1 on cycle 4 of the instruction.
  - STORE: d_wr=1 one cycle with d_addr=0xA3, rf_ra_addr=7.
- SUB and illegal opcode: 16'h4AB0 -> alu_op=2, rf_w_addr=0. 16'hF123 -> 3-cycle NOOP with no strobes.
- HALT: 16'h5000 -> halted=1 from the cycle after DECODE, pc_addr frozen at 1 for 20 cycles, no strobes. Pulse reset -> pc_addr=0, halted=0.
- PC wrap: 128 NOOP instructions -> pc_addr goes 127 then 0. Fetch at 0 proceeds normally.
- Reset mid-LOAD: assert reset during LOAD_A -> outputs zero before the next edge, no rf_w_en pulse. After release, state_o shows INIT.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit CPU control path.
// Covers opcodes, FSM states, ALU function codes and IR field positions.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'h0,
        OP_STORE = 4'h1,
        OP_LOAD  = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_HALT  = 4'h5
    } opcode_t;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    // IR field positions
    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 12;
    localparam int DADDR_MSB = 11;
    localparam int DADDR_LSB = 4;
    localparam int RA_MSB    = 11;
    localparam int RA_LSB    = 8;
    localparam int RB_MSB    = 7;
    localparam int RB_LSB    = 4;
    localparam int RD_MSB    = 3;
    localparam int RD_LSB    = 0;

endpackage

// File: rtl/cpu_control_unit_pc.sv
// Program counter: clear has priority over increment; the increment wraps
// from the all-ones value back to zero.
module cpu_pc #(
    parameter int PC_WIDTH = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                inc,
    output logic [PC_WIDTH-1:0] pc
);

    logic [PC_WIDTH-1:0] pc_d, pc_q;

    always_comb begin
        pc_d = pc_q;
        if (clr)
            pc_d = '0;
        else if (inc)
            pc_d = (pc_q == {PC_WIDTH{1'b1}}) ? '0 : pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc_q <= '0;
        else
            pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: rtl/cpu_control_unit.sv
// Multicycle control FSM for the 16-bit CPU: owns PC and IR, sequences
// fetch/decode/execute and drives register-file, data-memory and ALU controls.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = 7,
    parameter int DADDR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            instr,
    output logic [PC_WIDTH-1:0]    pc_addr,
    output logic [DADDR_WIDTH-1:0] d_addr,
    output logic                   d_wr,
    output logic                   rf_sel,
    output logic [3:0]             rf_w_addr,
    output logic                   rf_w_en,
    output logic [3:0]             rf_ra_addr,
    output logic [3:0]             rf_rb_addr,
    output logic [2:0]             alu_op,
    output logic                   halted,
    output logic [3:0]             state_o
);

    state_t      state_d, state_q;
    logic [15:0] ir_d, ir_q;
    logic        pc_clr, pc_inc;

    cpu_pc #(.PC_WIDTH(PC_WIDTH)) u_pc (
        .clk   (clk),
        .reset (reset),
        .clr   (pc_clr),
        .inc   (pc_inc),
        .pc    (pc_addr)
    );

    // Outputs depend only on state_q and ir_q, so the async reset of those
    // flops zeroes every strobe and address without waiting for an edge.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        pc_clr     = 1'b0;
        pc_inc     = 1'b0;
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_sel     = 1'b0;
        rf_w_addr  = '0;
        rf_w_en    = 1'b0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_op     = ALU_PASS;
        halted     = 1'b0;

        case (state_q)
            S_INIT: begin
                pc_clr  = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = instr;
                pc_inc  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (ir_q[OPC_MSB:OPC_LSB])
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    default:  state_d = S_NOOP;
                endcase
            end
            S_NOOP: state_d = S_FETCH;
            S_LOAD_A: begin
                // Memory read is synchronous: address now, write back next cycle
                d_addr  = DADDR_WIDTH'(ir_q[DADDR_MSB:DADDR_LSB]);
                rf_sel  = 1'b1;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                d_addr    = DADDR_WIDTH'(ir_q[DADDR_MSB:DADDR_LSB]);
                rf_sel    = 1'b1;
                rf_w_addr = ir_q[RD_MSB:RD_LSB];
                rf_w_en   = 1'b1;
                state_d   = S_FETCH;
            end
            S_STORE: begin
                d_addr     = DADDR_WIDTH'(ir_q[DADDR_MSB:DADDR_LSB]);
                rf_ra_addr = ir_q[RD_MSB:RD_LSB];
                d_wr       = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADD, S_SUB: begin
                rf_ra_addr = ir_q[RA_MSB:RA_LSB];
                rf_rb_addr = ir_q[RB_MSB:RB_LSB];
                rf_w_addr  = ir_q[RD_MSB:RD_LSB];
                rf_w_en    = 1'b1;
                alu_op     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
                state_d    = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit with a behavioural instruction ROM.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr;
    logic [6:0]  pc_addr;
    logic [7:0]  d_addr;
    logic        d_wr, rf_sel, rf_w_en, halted;
    logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, state_o;
    logic [2:0]  alu_op;

    logic [15:0] rom [128];
    int n_chk = 0;
    int n_err = 0;

    assign instr = rom[pc_addr];

    always #5 clk = ~clk;

    cpu_control_unit #(.PC_WIDTH(7), .DADDR_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .pc_addr    (pc_addr),
        .d_addr     (d_addr),
        .d_wr       (d_wr),
        .rf_sel     (rf_sel),
        .rf_w_addr  (rf_w_addr),
        .rf_w_en    (rf_w_en),
        .rf_ra_addr (rf_ra_addr),
        .rf_rb_addr (rf_rb_addr),
        .alu_op     (alu_op),
        .halted     (halted),
        .state_o    (state_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench in the INIT cycle right after reset release
    task automatic do_reset();
        reset = 1'b1;
        skip(2);
        reset = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".d_wr"}, d_wr, 0);
        chk({tag, ".w_en"}, rf_w_en, 0);
    endtask

    initial begin
        clear_rom();

        // Reset state and ADD
        rom[0] = 16'h3125;
        reset = 1'b1;
        skip(1);
        chk("rst.state", state_o, 0);
        chk("rst.pc", pc_addr, 0);
        chk("rst.halted", halted, 0);
        chk("rst.d_addr", d_addr, 0);
        chk_quiet("rst");
        skip(1);
        reset = 1'b0;
        chk("init.state", state_o, 0);
        skip(1);
        chk("fetch.state", state_o, 1);
        chk("fetch.pc", pc_addr, 0);
        skip(1);
        chk("decode.state", state_o, 2);
        chk("decode.pc", pc_addr, 1);
        chk_quiet("decode");
        skip(1);
        chk("add.state", state_o, 7);
        chk("add.ra", rf_ra_addr, 1);
        chk("add.rb", rf_rb_addr, 2);
        chk("add.wa", rf_w_addr, 5);
        chk("add.alu", alu_op, 1);
        chk("add.sel", rf_sel, 0);
        chk("add.w_en", rf_w_en, 1);
        skip(1);
        chk("add_next.state", state_o, 1);
        chk("add_next.w_en", rf_w_en, 0);

        // LOAD then STORE
        clear_rom();
        rom[0] = 16'h2A37;
        rom[1] = 16'h1A37;
        do_reset();
        skip(3);
        chk("ldA.state", state_o, 4);
        chk("ldA.d_addr", d_addr, 8'hA3);
        chk("ldA.sel", rf_sel, 1);
        chk_quiet("ldA");
        skip(1);
        chk("ldB.state", state_o, 5);
        chk("ldB.d_addr", d_addr, 8'hA3);
        chk("ldB.sel", rf_sel, 1);
        chk("ldB.wa", rf_w_addr, 7);
        chk("ldB.w_en", rf_w_en, 1);
        chk("ldB.d_wr", d_wr, 0);
        skip(1);
        chk("ld_next.state", state_o, 1);
        chk_quiet("ld_next");
        skip(2);
        chk("st.state", state_o, 6);
        chk("st.d_wr", d_wr, 1);
        chk("st.d_addr", d_addr, 8'hA3);
        chk("st.ra", rf_ra_addr, 7);
        chk("st.w_en", rf_w_en, 0);
        skip(1);
        chk("st_next.d_wr", d_wr, 0);
        chk("st_next.pc", pc_addr, 2);

        // SUB then illegal opcode as NOOP
        clear_rom();
        rom[0] = 16'h4AB0;
        rom[1] = 16'hF123;
        do_reset();
        skip(3);
        chk("sub.state", state_o, 8);
        chk("sub.alu", alu_op, 2);
        chk("sub.wa", rf_w_addr, 0);
        chk("sub.ra", rf_ra_addr, 4'hA);
        chk("sub.rb", rf_rb_addr, 4'hB);
        chk("sub.w_en", rf_w_en, 1);
        skip(2);
        chk("ill.decode", state_o, 2);
        skip(1);
        chk("ill.state", state_o, 3);
        chk_quiet("ill");
        skip(1);
        chk("ill.fetch", state_o, 1);
        chk("ill.pc", pc_addr, 2);

        // HALT
        clear_rom();
        rom[0] = 16'h5000;
        do_reset();
        skip(2);
        chk("halt.pre", halted, 0);
        skip(1);
        for (int i = 0; i < 20; i++) begin
            chk("halt.halted", halted, 1);
            chk("halt.pc", pc_addr, 1);
            chk_quiet("halt");
            skip(1);
        end
        reset = 1'b1;
        #1;
        chk("halt_rst.pc", pc_addr, 0);
        chk("halt_rst.halted", halted, 0);
        skip(1);

        // PC wrap
        clear_rom();
        do_reset();
        skip(1);
        chk("wrap.first_pc", pc_addr, 0);
        for (int i = 0; i < 128; i++) begin
            skip(1);
            if (i == 126) chk("wrap.pc127", pc_addr, 127);
            if (i == 127) chk("wrap.pc0", pc_addr, 0);
            skip(2);
        end
        chk("wrap.fetch", state_o, 1);
        skip(1);
        chk("wrap.decode", state_o, 2);
        chk("wrap.pc1", pc_addr, 1);

        // Reset in the middle of LOAD
        clear_rom();
        rom[0] = 16'h2A37;
        do_reset();
        skip(3);
        chk("mid.ldA", state_o, 4);
        #2;
        reset = 1'b1;
        #1;
        chk("mid.state", state_o, 0);
        chk("mid.d_addr", d_addr, 0);
        chk("mid.sel", rf_sel, 0);
        chk_quiet("mid");
        @(posedge clk);
        #1;
        chk("mid_edge.w_en", rf_w_en, 0);
        chk("mid_edge.state", state_o, 0);
        skip(1);
        reset = 1'b0;
        #1;
        chk("mid_rel.state", state_o, 0);
        skip(1);
        chk("mid_rel.fetch", state_o, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
